// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline definitions: stall/flush sequencer state encoding,
// default multdiv timeout and the latch-control bundle layout.
package pipe_stall_ctrl_pkg;

  // Default number of BUSY cycles allowed before the math exception fires
  localparam int MD_TIMEOUT_DEF = 40;

  // Default width of the busy-cycle counter (2**6 = 64 > 40)
  localparam int CNT_W_DEF = 6;

  // Sequencer states: IDLE runs the pipe, BUSY holds X for mult/div
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Enables and flushes for the PC register and the pipeline latches,
  // ordered {pcEn, fdEn, dxEn, xmEn, mwEn, fdClr, dxClr, xmClr}
  typedef struct packed {
    logic pcEn;
    logic fdEn;
    logic dxEn;
    logic xmEn;
    logic mwEn;
    logic fdClr;
    logic dxClr;
    logic xmClr;
  } latch_ctrl_t;

  // Everything frozen and flushed while the pipeline is in reset
  localparam latch_ctrl_t CTRL_RESET   = 8'b00000_111;
  // Normal flow: every stage advances, nothing is squashed
  localparam latch_ctrl_t CTRL_RUN     = 8'b11111_000;
  // Taken branch/jump: PC loads the target, wrong-path F and D squashed
  localparam latch_ctrl_t CTRL_BRANCH  = 8'b11111_110;
  // Load-use: hold PC and F/D, push a bubble into X
  localparam latch_ctrl_t CTRL_LOADUSE = 8'b00111_010;
  // Mult/div in X: freeze the front end, drain bubbles behind X
  localparam latch_ctrl_t CTRL_HOLDX   = 8'b00011_001;

  // Terminal-count helper: true when the counter sits on the last
  // allowed BUSY cycle
  function automatic logic isTerminal(input logic [31:0] cnt, input int timeout);
    return cnt == 32'(timeout - 1);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_counter.sv
// md_timeout_counter: busy-cycle counter for the multdiv wait, with a
// synchronous clear and an increment, flagging the last allowed cycle.
module md_timeout_counter
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      w_cntWide;

  // Count BUSY cycles; clear wins so a fresh operation always starts at 0
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Terminal count marks the cycle where the timeout exception is due
  always_comb begin
    w_cntWide = 32'(r_cnt);
    o_tc      = isTerminal(w_cntWide, MD_TIMEOUT);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: hazard and stall sequencer for the 5-stage pipeline.
// Resolves load-use stalls, taken-branch flushes and multi-cycle mult/div
// holds, including the multdiv timeout exception.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic loadUse,
  input  logic branchTaken,
  input  logic mdStart,
  input  logic mdRdy,
  output logic pcEn,
  output logic fdEn,
  output logic dxEn,
  output logic xmEn,
  output logic mwEn,
  output logic fdClr,
  output logic dxClr,
  output logic xmClr,
  output logic mdGo,
  output logic mdBusy,
  output logic mdExcep
);

  state_t           r_state;
  state_t           w_nextState;
  latch_ctrl_t      w_ctrl;
  logic             w_mdGo;
  logic             w_mdBusy;
  logic             w_mdExcep;
  logic             w_busyExit;
  logic             w_cntClear;
  logic             w_cntInc;
  logic             w_tc;
  logic [CNT_W-1:0] w_cnt;

  // The counter only runs while BUSY and is parked at zero otherwise,
  // so entering BUSY always starts from a clean count
  assign w_cntClear = clr | (r_state == ST_IDLE) | w_busyExit;
  assign w_cntInc   = (r_state == ST_BUSY) & ~w_busyExit;

  md_timeout_counter #(
    .MD_TIMEOUT (MD_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_counter (
    .clk     (clk),
    .i_clear (w_cntClear),
    .i_inc   (w_cntInc),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

  // State register; reset drops any outstanding mult/div back to IDLE
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and latch controls; hazard priority is branch > mult/div > load-use
  always_comb begin
    w_nextState = r_state;
    w_ctrl      = CTRL_RUN;
    w_mdGo      = 1'b0;
    w_mdBusy    = 1'b0;
    w_mdExcep   = 1'b0;
    w_busyExit  = 1'b0;

    if (clr) begin
      w_ctrl      = CTRL_RESET;
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (branchTaken) begin
            w_ctrl = CTRL_BRANCH;
          end else if (mdStart) begin
            w_ctrl      = CTRL_HOLDX;
            w_mdGo      = 1'b1;
            w_nextState = ST_BUSY;
          end else if (loadUse) begin
            w_ctrl = CTRL_LOADUSE;
          end
        end
        ST_BUSY: begin
          w_mdBusy = 1'b1;
          if (mdRdy) begin
            w_ctrl      = CTRL_RUN;
            w_busyExit  = 1'b1;
            w_nextState = ST_IDLE;
          end else if (w_tc) begin
            w_ctrl      = CTRL_RUN;
            w_mdExcep   = 1'b1;
            w_busyExit  = 1'b1;
            w_nextState = ST_IDLE;
          end else begin
            w_ctrl = CTRL_HOLDX;
          end
        end
        default: begin
          w_nextState = ST_IDLE;
        end
      endcase
    end
  end

  // The count value itself only matters through the terminal flag
  logic w_cntUnused;
  assign w_cntUnused = ^w_cnt;

  assign pcEn    = w_ctrl.pcEn;
  assign fdEn    = w_ctrl.fdEn;
  assign dxEn    = w_ctrl.dxEn;
  assign xmEn    = w_ctrl.xmEn;
  assign mwEn    = w_ctrl.mwEn;
  assign fdClr   = w_ctrl.fdClr;
  assign dxClr   = w_ctrl.dxClr;
  assign xmClr   = w_ctrl.xmClr;
  assign mdGo    = w_mdGo;
  assign mdBusy  = w_mdBusy;
  assign mdExcep = w_mdExcep;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with hand-computed output vectors.
module tb_pipe_stall_ctrl;

  logic clk;
  logic clr;
  logic loadUse;
  logic branchTaken;
  logic mdStart;
  logic mdRdy;
  logic pcEn, fdEn, dxEn, xmEn, mwEn;
  logic fdClr, dxClr, xmClr;
  logic mdGo, mdBusy, mdExcep;

  int compareCount = 0;
  int errCount     = 0;

  // Output vector layout: {pcEn,fdEn,dxEn,xmEn,mwEn, fdClr,dxClr,xmClr, mdGo,mdBusy,mdExcep}
  localparam logic [10:0] V_RST     = 11'b00000_111_000;
  localparam logic [10:0] V_IDLE    = 11'b11111_000_000;
  localparam logic [10:0] V_LOADUSE = 11'b00111_010_000;
  localparam logic [10:0] V_BRANCH  = 11'b11111_110_000;
  localparam logic [10:0] V_GO      = 11'b00011_001_100;
  localparam logic [10:0] V_BUSY    = 11'b00011_001_010;
  localparam logic [10:0] V_DONE    = 11'b11111_000_010;
  localparam logic [10:0] V_EXC     = 11'b11111_000_011;

  pipe_stall_ctrl #(
    .MD_TIMEOUT (40),
    .CNT_W      (6)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .loadUse     (loadUse),
    .branchTaken (branchTaken),
    .mdStart     (mdStart),
    .mdRdy       (mdRdy),
    .pcEn        (pcEn),
    .fdEn        (fdEn),
    .dxEn        (dxEn),
    .xmEn        (xmEn),
    .mwEn        (mwEn),
    .fdClr       (fdClr),
    .dxClr       (dxClr),
    .xmClr       (xmClr),
    .mdGo        (mdGo),
    .mdBusy      (mdBusy),
    .mdExcep     (mdExcep)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle's inputs on the falling edge, away from the state update
  task automatic applyStimulus(input logic c, input logic br, input logic ms,
                               input logic lu, input logic rdy);
    @(negedge clk);
    clr         = c;
    branchTaken = br;
    mdStart     = ms;
    loadUse     = lu;
    mdRdy       = rdy;
  endtask

  // Compare the full combinational output vector mid-cycle
  task automatic checkOutput(input string tag, input logic [10:0] expVec);
    logic [10:0] obsVec;
    #1;
    obsVec = {pcEn, fdEn, dxEn, xmEn, mwEn, fdClr, dxClr, xmClr, mdGo, mdBusy, mdExcep};
    compareCount++;
    assert (obsVec === expVec) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obsVec, expVec);
    end
  endtask

  task automatic step(input logic c, input logic br, input logic ms,
                      input logic lu, input logic rdy,
                      input string tag, input logic [10:0] expVec);
    applyStimulus(c, br, ms, lu, rdy);
    checkOutput(tag, expVec);
  endtask

  initial begin
    clr         = 1'b1;
    branchTaken = 1'b0;
    mdStart     = 1'b0;
    loadUse     = 1'b0;
    mdRdy       = 1'b0;

    // Reset held two cycles, then released with idle inputs
    step(1, 0, 0, 0, 0, "reset_c0", V_RST);
    step(1, 1, 1, 1, 1, "reset_c1_inputs_masked", V_RST);
    step(0, 0, 0, 0, 0, "after_reset_idle", V_IDLE);

    // Load-use stall lasts one cycle only
    step(0, 0, 0, 1, 0, "loaduse_stall", V_LOADUSE);
    step(0, 0, 0, 0, 0, "loaduse_release", V_IDLE);
    step(0, 0, 0, 1, 0, "loaduse_again", V_LOADUSE);

    // Branch beats load-use and mult/div
    step(0, 1, 0, 1, 0, "branch_over_loaduse", V_BRANCH);
    step(0, 1, 1, 0, 0, "branch_over_mdstart", V_BRANCH);
    step(0, 0, 0, 0, 0, "branch_no_busy_after", V_IDLE);

    // Normal mult: go at cycle 0, mdRdy at cycle 17; stray hazards ignored while BUSY
    step(0, 0, 1, 1, 0, "mult_go", V_GO);
    for (int k = 1; k <= 16; k++) begin
      step(0, (k == 3), (k == 5), (k == 7), 0, "mult_busy", V_BUSY);
    end
    step(0, 0, 0, 0, 1, "mult_done", V_DONE);
    step(0, 0, 0, 0, 0, "mult_back_idle", V_IDLE);
    step(0, 0, 0, 0, 1, "rdy_in_idle_ignored", V_IDLE);

    // Timeout: mdRdy in the go cycle is ignored, exception on BUSY cycle 40
    step(0, 0, 1, 0, 1, "to_go_rdy_ignored", V_GO);
    for (int k = 1; k <= 39; k++) begin
      step(0, (k % 3 == 0), 0, (k % 4 == 0), 0, "to_busy", V_BUSY);
    end
    step(0, 0, 0, 0, 0, "to_excep", V_EXC);
    for (int k = 41; k <= 44; k++) begin
      step(0, 0, 0, 0, 0, "to_idle_after", V_IDLE);
    end
    step(0, 0, 0, 0, 1, "to_late_rdy_ignored", V_IDLE);
    step(0, 0, 0, 0, 0, "to_still_idle", V_IDLE);

    // Back-to-back mul: held mdStart is ignored in BUSY, reissued once IDLE
    step(0, 0, 1, 0, 0, "b2b_go1", V_GO);
    step(0, 0, 1, 0, 0, "b2b_no_double_go", V_BUSY);
    step(0, 0, 1, 0, 0, "b2b_busy2", V_BUSY);
    step(0, 0, 1, 0, 1, "b2b_done1", V_DONE);
    step(0, 0, 1, 0, 0, "b2b_go2", V_GO);

    // Reset during BUSY cycle 5 abandons the op with no reissue
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0, 0, "clr_pre_busy", V_BUSY);
    end
    step(1, 0, 0, 0, 0, "clr_mid_busy", V_RST);
    step(0, 0, 0, 0, 0, "clr_after_idle", V_IDLE);
    step(0, 0, 0, 0, 0, "clr_no_reissue", V_IDLE);

    // Counter restarted from zero: mdRdy on the terminal cycle wins over timeout
    step(0, 0, 1, 0, 0, "tc_go", V_GO);
    for (int k = 1; k <= 39; k++) begin
      step(0, 0, 0, 0, 0, "tc_busy", V_BUSY);
    end
    step(0, 0, 0, 0, 1, "tc_rdy_wins", V_DONE);
    step(0, 0, 0, 0, 0, "tc_back_idle", V_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errCount);
    $finish;
  end

endmodule
